pin_entry_buffer: RTL

PIN_ENTRY_BUFFER -- requirements
Module: pin_entry_buffer

---
 rtl/pin_entry_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pin_entry_buffer.sv
// PIN entry buffer: collects up to four BCD digits from a keypad strobe, with backspace/clear.
// Optional inactivity auto-clear is compiled in only when PIN_ENTRY_TIMEOUT_EN is defined.
module pin_entry_buffer #(
    parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        consume,
    output logic [15:0] value_16bit,
    output logic        enough,
    output logic [2:0]  digit_count,
    output logic        timeout_flag,
    output logic [1:0]  dbg_state
);
    // Handshake: key_valid and consume are single-cycle strobes with no ready; every strobe is
    // sampled on the rising edge it is high for, and results are visible the following cycle.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] value_q, value_d;
    logic [2:0]  count_q, count_d;

    logic is_digit, is_bksp, is_clear;

    assign is_digit = (key_code <= 4'h9);
    assign is_bksp  = (key_code == 4'hA);
    assign is_clear = (key_code == 4'hB);

`ifdef PIN_ENTRY_TIMEOUT_EN
    localparam logic [27:0] TIMEOUT_LAST = 28'(TIMEOUT_CYCLES - 1);

    logic [27:0] timer_q, timer_d;
    logic        timeout_q, timeout_d;
    logic        key_accepted;

    // Only keys that actually change the buffer restart the timer or beat a timeout.
    assign key_accepted = key_valid && !consume &&
                          ((is_digit && (count_q < 3'd4)) ||
                           (is_bksp && (count_q != 3'd0)) ||
                           is_clear);
`endif

    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (consume) begin
            value_d = 16'h0000;
            count_d = 3'd0;
        end else if (key_valid) begin
            if (is_digit) begin
                if (count_q < 3'd4) begin
                    value_d = {value_q[11:0], key_code};
                    count_d = count_q + 3'd1;
                end
            end else if (is_bksp) begin
                if (count_q != 3'd0) begin
                    value_d = {4'h0, value_q[15:4]};
                    count_d = count_q - 3'd1;
                end
            end else if (is_clear) begin
                value_d = 16'h0000;
                count_d = 3'd0;
            end
        end

`ifdef PIN_ENTRY_TIMEOUT_EN
        timeout_d = 1'b0;
        timer_d   = timer_q;
        if (state_q != IDLE) begin
            timer_d = timer_q + 28'd1;
        end
        if (key_accepted) begin
            timer_d = 28'd0;
        end
        if ((state_q != IDLE) && !consume && !key_accepted && (timer_q == TIMEOUT_LAST)) begin
            value_d   = 16'h0000;
            count_d   = 3'd0;
            timeout_d = 1'b1;
        end
        if (count_d == 3'd0) begin
            timer_d = 28'd0;
        end
`endif

        if (count_d == 3'd0) begin
            state_d = IDLE;
        end else if (count_d == 3'd4) begin
            state_d = FULL;
        end else begin
            state_d = ENTRY;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
            value_q <= 16'h0000;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            count_q <= count_d;
        end
    end

`ifdef PIN_ENTRY_TIMEOUT_EN
    always_ff @(posedge clk_in) begin
        if (rst) begin
            timer_q   <= 28'd0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_flag = timeout_q;
`else
    assign timeout_flag = 1'b0;
`endif

    assign value_16bit = value_q;
    assign digit_count = count_q;
    assign enough      = (state_q == FULL);
    assign dbg_state   = state_q;

endmodule
